// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the float32 operator-sharing arbiter.
// The top level has an optional watchdog, enabled with FP_ARB_TIMEOUT_EN.
package fp_arb_pkg;

    localparam int          FP_WIDTH = 32;
    localparam logic [31:0] FP_QNAN  = 32'h7FC00000;
    localparam logic [31:0] FP_ONE   = 32'h3F800000;
    localparam logic [31:0] FP_TWO   = 32'h40000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_Z = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first set request bit
// found searching upward from ptr, wrapping around past N-1.
module rr_pick
    import fp_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          vld,
    output logic [IW-1:0] idx
);

    // Walk from the farthest candidate toward ptr, so the closest hit wins.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                vld = 1'b1;
                idx = IW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one stb/ack float32 operator core between
// NUM_REQ requesters. Only one operation is in flight at a time.
// Optional watchdog: define FP_ARB_TIMEOUT_EN to abort a stuck core after
// TIMEOUT_CYCLES and return a qNaN with resp_err set.
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = FP_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_z,
    output logic                     resp_err,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic                     fu_rst,
    output logic [WIDTH-1:0]         fu_a,
    output logic [WIDTH-1:0]         fu_b,
    output logic                     fu_a_stb,
    output logic                     fu_b_stb,
    input  logic                     fu_a_ack,
    input  logic                     fu_b_ack,
    input  logic [WIDTH-1:0]         fu_z,
    input  logic                     fu_z_stb,
    output logic                     fu_z_ack
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t        state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     gnt_idx;
    logic              pick_vld;
    logic [IW-1:0]     pick_idx;
    logic [WIDTH-1:0]  a_arr [NUM_REQ];
    logic [WIDTH-1:0]  b_arr [NUM_REQ];
    logic              a_done;
    logic              b_done;
    logic              to_hit;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    // A strobe that is already low was acknowledged in an earlier cycle.
    assign a_done = !fu_a_stb || fu_a_ack;
    assign b_done = !fu_b_stb || fu_b_ack;

`ifdef FP_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

    logic [TO_W-1:0] to_cnt;
    logic            busy;
    logic            adv;

    assign busy   = (state == ISSUE) || (state == WAIT_Z);
    assign adv    = ((state == ISSUE) && a_done && b_done) ||
                    ((state == WAIT_Z) && fu_z_stb);
    assign to_hit = busy && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts cycles spent in the current busy state, clears on any state change.
    always_ff @(posedge CLK) begin
        if (!RST || !busy || adv || to_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign to_hit         = 1'b0;
    assign resp_err       = 1'b0;
`endif

    // Grant / issue / collect / respond sequencer; all outputs are registered.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_idx    <= '0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_z     <= '0;
            fu_a       <= '0;
            fu_b       <= '0;
            fu_a_stb   <= 1'b0;
            fu_b_stb   <= 1'b0;
            fu_z_ack   <= 1'b0;
            fu_rst     <= 1'b1;
`ifdef FP_ARB_TIMEOUT_EN
            resp_err   <= 1'b0;
`endif
        end else begin
            req_ready <= '0;
            fu_z_ack  <= 1'b0;
            fu_rst    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_idx             <= pick_idx;
                        fu_a                <= a_arr[pick_idx];
                        fu_b                <= b_arr[pick_idx];
                        fu_a_stb            <= 1'b1;
                        fu_b_stb            <= 1'b1;
                        req_ready[pick_idx] <= 1'b1;
                        state               <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (fu_a_ack) fu_a_stb <= 1'b0;
                    if (fu_b_ack) fu_b_stb <= 1'b0;
                    if (a_done && b_done) state <= WAIT_Z;
                end
                WAIT_Z: begin
                    if (fu_z_stb) begin
                        resp_z              <= fu_z;
                        fu_z_ack            <= 1'b1;
                        resp_valid[gnt_idx] <= 1'b1;
                        state               <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[gnt_idx]) begin
                        resp_valid <= '0;
                        ptr        <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        state      <= IDLE;
`ifdef FP_ARB_TIMEOUT_EN
                        resp_err   <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase

            // Abort overrides whatever the core did this cycle.
            if (to_hit) begin
                fu_rst              <= 1'b1;
                fu_a_stb            <= 1'b0;
                fu_b_stb            <= 1'b0;
                fu_z_ack            <= 1'b0;
                resp_z              <= WIDTH'(FP_QNAN);
                resp_valid[gnt_idx] <= 1'b1;
                state               <= RESP;
`ifdef FP_ARB_TIMEOUT_EN
                resp_err            <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Scoreboard bench for fp_unit_arbiter with a behavioural stb/ack core model.
module tb_fp_unit_arbiter;
    import fp_arb_pkg::*;

`ifdef FP_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic         CLK, RST;
    logic [3:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [127:0] req_a, req_b;
    logic [31:0]  resp_z, fu_a, fu_b, fu_z;
    logic         resp_err, fu_rst, fu_a_stb, fu_b_stb, fu_a_ack, fu_b_ack, fu_z_stb, fu_z_ack;

    fp_unit_arbiter #(.NUM_REQ(4), .WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_z(resp_z), .resp_err(resp_err), .resp_ready(resp_ready),
        .fu_rst(fu_rst), .fu_a(fu_a), .fu_b(fu_b), .fu_a_stb(fu_a_stb), .fu_b_stb(fu_b_stb),
        .fu_a_ack(fu_a_ack), .fu_b_ack(fu_b_ack), .fu_z(fu_z), .fu_z_stb(fu_z_stb), .fu_z_ack(fu_z_ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct { int idx; logic [31:0] z; logic err; } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Mock adder: real sums for the float cases used, an XOR mix otherwise.
    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == FP_ONE && b == FP_TWO) return 32'h40400000;
        if (a == FP_TWO && b == FP_TWO) return 32'h40800000;
        return a ^ b;
    endfunction

    // ---- requester side: per-requester operand FIFOs ----
    logic [31:0] qa [4][4];
    logic [31:0] qb [4][4];
    int qh [4];
    int qt [4];
    int present_cyc [4];
    bit lat_chk = 0;

    task automatic send(input int i, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        qa[i][qt[i] % 4] = a;
        qb[i][qt[i] % 4] = b;
        qt[i]++;
        if (push) begin
            e.idx = i; e.z = core_fn(a, b); e.err = 1'b0;
            sb.push_back(e);
        end
    endtask

    initial begin
        req_valid = '0; req_a = '0; req_b = '0;
        forever begin
            @(posedge CLK); #1;
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (lat_chk) chk("grant_lat", cyc - present_cyc[i], 1);
                    qh[i]++;
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && qh[i] != qt[i]) begin
                    req_valid[i]      = 1'b1;
                    req_a[i*32 +: 32] = qa[i][qh[i] % 4];
                    req_b[i*32 +: 32] = qb[i][qh[i] % 4];
                    present_cyc[i]    = cyc;
                end
            end
        end
    end

    // ---- core model ----
    int a_dly = 0, b_dly = 0, z_lat = 2;
    bit z_never = 0, stale_on = 0;
    bit a_got, b_got, z_act;
    int a_w, b_w, z_w;
    logic [31:0] ra, rb;

    initial begin
        fu_a_ack = 0; fu_b_ack = 0; fu_z_stb = 0; fu_z = '0;
        a_got = 0; b_got = 0; z_act = 0; a_w = 0; b_w = 0; z_w = 0;
        forever begin
            @(posedge CLK); #1;
            fu_a_ack = 1'b0; fu_b_ack = 1'b0;
            if (stale_on) begin
                fu_z_stb = 1'b1; fu_z = 32'hDEADBEEF;
            end else if (fu_rst) begin
                a_got = 0; b_got = 0; z_act = 0; a_w = 0; b_w = 0; z_w = 0;
                fu_z_stb = 1'b0;
            end else begin
                if (fu_a_stb && !a_got) begin
                    if (a_w == a_dly) begin fu_a_ack = 1'b1; a_got = 1; ra = fu_a; end
                    else a_w++;
                end
                if (fu_b_stb && !b_got) begin
                    if (b_w == b_dly) begin fu_b_ack = 1'b1; b_got = 1; rb = fu_b; end
                    else b_w++;
                end
                if (z_act && fu_z_ack) begin
                    z_act = 0; a_got = 0; b_got = 0; a_w = 0; b_w = 0; z_w = 0;
                end else if (a_got && b_got && !z_act && !z_never) begin
                    if (z_w == z_lat) begin z_act = 1; fu_z = core_fn(ra, rb); end
                    else z_w++;
                end
                fu_z_stb = z_act;
            end
        end
    end

    // ---- response monitor: pops scoreboard, applies optional back-pressure ----
    int bp_len = 0;
    initial begin
        bit in_resp;
        int hold, zrun;
        exp_t e;
        in_resp = 0; hold = 0; zrun = 0;
        resp_ready = '0;
        forever begin
            @(posedge CLK); #1;
            resp_ready = '0;
            if (fu_z_ack) zrun++;
            else if (zrun != 0) begin chk("zack_len", zrun, 1); zrun = 0; end
            if (resp_valid != 0) begin
                if (!in_resp) begin in_resp = 1; hold = bp_len; end
                if (sb.size() == 0) begin
                    chk("resp_unexp", resp_valid, 0);
                    resp_ready = resp_valid;
                end else if (hold > 0) begin
                    chk("bp_vld", resp_valid, 32'd1 << sb[0].idx);
                    chk("bp_z", resp_z, sb[0].z);
                    chk("bp_nogrant", req_ready, 0);
                    hold--;
                end else begin
                    e = sb.pop_front();
                    chk("resp_vld", resp_valid, 32'd1 << e.idx);
                    chk("resp_z", resp_z, e.z);
                    chk("resp_err", resp_err, e.err);
                    resp_ready = resp_valid;
                end
            end else in_resp = 0;
        end
    end

    function automatic bit pending();
        for (int i = 0; i < 4; i++) if (qh[i] != qt[i]) return 1;
        return sb.size() != 0 || resp_valid != 0 || req_valid != 0;
    endfunction

    task automatic wait_idle(input int max);
        for (int n = 0; n < max && pending(); n++) @(negedge CLK);
        chk("drain", sb.size(), 0);
    endtask

    // ---- main sequence ----
    logic [4:0] stag_a, stag_b;
    initial begin
        stag_a = 5'b00001;  // index k-1 = ISSUE cycle k
        stag_b = 5'b01111;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_fu_rst", fu_rst, 1);
        chk("rst_ctl", {req_ready, resp_valid, fu_a_stb, fu_b_stb, fu_z_ack, resp_err}, 0);
        chk("rst_z", resp_z, 0);
        chk("rst_fua", fu_a, 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_release", fu_rst, 0);

        // single request, 1.0 + 2.0
        lat_chk = 1;
        send(0, FP_ONE, FP_TWO, 1);
        wait_idle(200);
        lat_chk = 0;

        // staggered acks on requester 3
        b_dly = 3;
        send(3, 32'h11111111, 32'h22220000, 1);
        for (int k = 0; k < 20 && !req_ready[3]; k++) @(negedge CLK);
        chk("stag_gnt", req_ready[3], 1);
        for (int k = 0; k < 5; k++) begin
            chk("stag_a_stb", fu_a_stb, stag_a[k]);
            chk("stag_b_stb", fu_b_stb, stag_b[k]);
            @(negedge CLK);
        end
        wait_idle(200);
        b_dly = 0;

        // reset while waiting on the core; a stale z strobe must not leak out
        z_never = 1;
        send(1, FP_TWO, FP_TWO, 0);
        for (int k = 0; k < 20 && !req_ready[1]; k++) @(negedge CLK);
        chk("mid_gnt", req_ready[1], 1);
        repeat (3) @(negedge CLK);
        chk("mid_waitz", {fu_a_stb, fu_b_stb}, 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_fu_rst", fu_rst, 1);
        chk("mid_resp_vld", resp_valid, 0);
        chk("mid_zack", fu_z_ack, 0);
        RST = 1'b1;
        z_never = 0;
        stale_on = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("stale_vld", resp_valid, 0);
            chk("stale_zack", fu_z_ack, 0);
        end
        stale_on = 0;
        @(negedge CLK);

        // fairness: all four requesting, pointer back at 0 -> 0,1,2,3,0
        send(0, FP_TWO, FP_TWO, 1);
        send(1, 32'h00000101, 32'h10100000, 1);
        send(2, 32'h00000202, 32'h20200000, 1);
        send(3, 32'h00000303, 32'h30300000, 1);
        send(0, 32'h00000404, 32'h40400000, 1);
        wait_idle(400);

        // back-pressure on requester 2 while requester 0 waits
        bp_len = 10;
        send(2, 32'hCAFE0000, 32'h0000BABE, 1);
        for (int k = 0; k < 100 && !resp_valid[2]; k++) @(negedge CLK);
        chk("bp_seen", resp_valid[2], 1);
        bp_len = 0;
        send(0, FP_ONE, FP_TWO, 1);
        wait_idle(300);

`ifdef FP_ARB_TIMEOUT_EN
        begin
            exp_t e;
            z_never = 1;
            send(1, FP_ONE, FP_ONE, 0);
            e.idx = 1; e.z = FP_QNAN; e.err = 1'b1;
            sb.push_back(e);
            wait_idle(300);
            z_never = 0;
        end
`endif

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
